// File: rtl/img_mem_arb.sv
// Two-port arbiter sharing one single-port image memory between the filter
// engine (requester 0) and the image loader (requester 1), with burst-limited fairness.
module img_mem_arb #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [2:0] BURST_LIMIT = 3'(MAX_BURST);

    state_t        state;
    logic [2:0]    burst_cnt;
    logic          last_gnt;
    logic          burst_done;
    logic          gnt_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          rd_vld_p0;
    logic          rd_id_p0;
    logic          rd_vld_p1;
    logic          rd_id_p1;

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        return (cnt < BURST_LIMIT) ? cnt + 3'd1 : cnt;
    endfunction

    // Contention resolution: the owner keeps the port until its burst is used up;
    // with no owner, whoever was not served last goes first.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        burst_done = (burst_cnt >= BURST_LIMIT);
        if (!reset) begin
            if (req0 && req1) begin
                case (state)
                    OWN0:    if (burst_done) gnt1 = 1'b1; else gnt0 = 1'b1;
                    OWN1:    if (burst_done) gnt0 = 1'b1; else gnt1 = 1'b1;
                    default: if (last_gnt)   gnt0 = 1'b1; else gnt1 = 1'b1;
                endcase
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? we1    : we0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= 3'd0;
            last_gnt  <= 1'b1;
        end else if (gnt0) begin
            state     <= OWN0;
            last_gnt  <= 1'b0;
            burst_cnt <= (state == OWN0) ? sat_inc(burst_cnt) : 3'd1;
        end else if (gnt1) begin
            state     <= OWN1;
            last_gnt  <= 1'b1;
            burst_cnt <= (state == OWN1) ? sat_inc(burst_cnt) : 3'd1;
        end else begin
            state     <= IDLE;
            burst_cnt <= 3'd0;
        end
    end

    // Stage p0: memory command register plus read tag for the granted access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cen   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_vld_p0 <= 1'b0;
            rd_id_p0  <= 1'b0;
        end else begin
            mem_cen   <= gnt_any;
            mem_wen   <= gnt_any & sel_we;
            rd_vld_p0 <= gnt_any & ~sel_we;
            rd_id_p0  <= gnt1;
            if (gnt_any) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Stage p1: tag lines up with the cycle the memory presents read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_vld_p0;
            rd_id_p1  <= rd_id_p0;
        end
    end

    assign rvalid0 = rd_vld_p1 & ~rd_id_p1;
    assign rvalid1 = rd_vld_p1 &  rd_id_p1;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_img_mem_arb.sv
// Directed bench for img_mem_arb: grant order, burst fairness, memory command
// timing, read-return routing and reset behaviour against hand-computed values.
module tb_img_mem_arb;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_cen, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    img_mem_arb #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_cen(mem_cen), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency; address 5 holds 0x3C, others {a[3:0],a[3:0]}
    always @(posedge clk) begin
        if (mem_cen && !mem_wen)
            mem_rdata <= (mem_addr == 14'h0005) ? 8'h3C : {mem_addr[3:0], mem_addr[3:0]};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_gnt"},    32'({gnt0, gnt1}), 32'd0);
        check_val({tag, "_cmd"},    32'({mem_cen, mem_wen}), 32'd0);
        check_val({tag, "_addr"},   32'(mem_addr), 32'd0);
        check_val({tag, "_wdata"},  32'(mem_wdata), 32'd0);
        check_val({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        req0  = 1'b1;
        cycle();
        check_quiet("rst");
        req0 = 1'b0;
        do_reset();

        // Single read from requester 0
        req0 = 1'b1; addr0 = 14'h0005;
        #1;
        check_val("rd_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cycle();
        req0 = 1'b0;
        check_val("rd_cmd",  32'({mem_cen, mem_wen}), 32'b10);
        check_val("rd_addr", 32'(mem_addr), 32'h0005);
        check_val("rd_early_rvalid", 32'({rvalid0, rvalid1}), 32'b00);
        cycle();
        check_val("rd_rvalid", 32'({rvalid0, rvalid1}), 32'b10);
        check_val("rd_rdata",  32'(rdata), 32'h3C);
        cycle();
        check_val("rd_rvalid_end", 32'({rvalid0, rvalid1}), 32'b00);
        check_val("rd_cen_off", 32'(mem_cen), 32'd0);

        // Write from requester 1 at the top address
        req1 = 1'b1; we1 = 1'b1; addr1 = 14'h3FFF; wdata1 = 8'hA5;
        #1;
        check_val("wr_gnt1", 32'({gnt0, gnt1}), 32'b01);
        cycle();
        idle_inputs();
        check_val("wr_cmd",   32'({mem_cen, mem_wen}), 32'b11);
        check_val("wr_addr",  32'(mem_addr), 32'h3FFF);
        check_val("wr_wdata", 32'(mem_wdata), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            check_val("wr_no_rvalid", 32'({rvalid0, rvalid1}), 32'b00);
            cycle();
        end
        check_val("wr_hold_addr", 32'(mem_addr), 32'h3FFF);

        // Simultaneous first request after reset
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check_val("sim_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cycle();
        req0 = 1'b0;
        #1;
        check_val("sim_gnt1", 32'({gnt0, gnt1}), 32'b01);
        cycle();
        check_val("sim_burst", 32'(dut.burst_cnt), 32'd1);
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();

        // Both held from reset: 4-grant bursts alternate
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        cycle();
        check_val("hold_rst_gnt", 32'({gnt0, gnt1}), 32'b00);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_val("hold_order", 32'({gnt0, gnt1}), ((i / 4) % 2 == 0) ? 32'b10 : 32'b01);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();

        // Lone requester is granted past the burst limit; counter saturates
        req0 = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_val("solo_gnt0", 32'({gnt0, gnt1}), 32'b10);
            cycle();
        end
        check_val("solo_sat", 32'(dut.burst_cnt), 32'd4);
        req0 = 1'b0;
        cycle();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check_val("idle_fair_gnt1", 32'({gnt0, gnt1}), 32'b01);
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();

        // Back-to-back reads by alternating requesters
        req0 = 1'b1; addr0 = 14'h0002;
        #1;
        check_val("b2b_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cycle();
        req0 = 1'b0; req1 = 1'b1; addr1 = 14'h0003;
        #1;
        check_val("b2b_gnt1", 32'({gnt0, gnt1}), 32'b01);
        cycle();
        idle_inputs();
        check_val("b2b_rv0", 32'({rvalid0, rvalid1}), 32'b10);
        check_val("b2b_rd0", 32'(rdata), 32'h22);
        cycle();
        check_val("b2b_rv1", 32'({rvalid0, rvalid1}), 32'b01);
        check_val("b2b_rd1", 32'(rdata), 32'h33);
        cycle();
        check_val("b2b_end", 32'({rvalid0, rvalid1}), 32'b00);
        cycle();

        // Reset one cycle after a read grant discards the in-flight read
        req0 = 1'b1; addr0 = 14'h0004;
        #1;
        check_val("rr_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cycle();
        reset = 1'b1;
        #1;
        check_quiet("rr_rst0");
        cycle();
        check_quiet("rr_rst1");
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            check_val("rr_no_rvalid", 32'({rvalid0, rvalid1}), 32'b00);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
